// File: rtl/instr_decode_pkg.sv
// Shared decode-stage types: scheduler state, nuke packet and instruction packet.
// Imported by the decode scheduler and anything that observes its state.
package instr_decode;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    FLUSH       = 2'd1,
    WAIT_RESUME = 2'd2,
    HALT        = 2'd3
  } t_de_sched_state;

  typedef struct packed {
    logic       valid;
    logic [5:0] rob_id;
  } t_nuke_pkt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
    logic [15:0] simid;
  } t_instr_pkt;

  localparam int STARVE_MAX_LIMIT = 15;

endpackage

// File: rtl/decode_sched.sv
// Decode-slot scheduler: arbitrates fetch vs injection into DE0 and sequences
// decode through nuke recovery and ebreak halt. Grants are combinational.
module decode_sched
  import instr_decode::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  t_nuke_pkt       nuke_rb1,
  input  logic            resume_fetch_rbx,
  input  logic            decode_ready_de0,
  input  logic            valid_fe1,
  input  t_instr_pkt      instr_fe1,
  output logic            fe_ready_fe1,
  input  logic            valid_inj,
  input  t_instr_pkt      instr_inj,
  output logic            inj_ready,
  input  logic            is_ebreak_de0,
  output logic            valid_de0,
  output t_instr_pkt      instr_de0,
  output logic            src_inj_de0,
  output t_de_sched_state state_de0
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  t_de_sched_state r_state;
  logic [CW-1:0]   r_starve_cnt;

  logic w_nuke;
  logic w_fetch_ok;
  logic w_inj_ok;
  logic w_starved;
  logic w_grant_fe;
  logic w_grant_inj;
  logic w_unused_nuke;

  assign w_nuke        = nuke_rb1.valid;
  assign w_unused_nuke = ^nuke_rb1.rob_id;

  // Reset gates eligibility so nothing is granted while reset is held.
  assign w_fetch_ok = ~reset & (r_state == RUN) & valid_fe1 & decode_ready_de0 & ~w_nuke;
  assign w_inj_ok   = ~reset & ((r_state == RUN) | (r_state == HALT)) & valid_inj
                    & decode_ready_de0 & ~w_nuke;

  assign w_starved   = (r_starve_cnt == STARVE_TOP);
  assign w_grant_fe  = w_fetch_ok & (~w_inj_ok | w_starved);
  assign w_grant_inj = w_inj_ok & ~w_grant_fe;

  assign fe_ready_fe1 = w_grant_fe;
  assign inj_ready    = w_grant_inj;
  assign valid_de0    = w_grant_fe | w_grant_inj;
  assign src_inj_de0  = w_grant_inj;
  assign state_de0    = reset ? RUN : r_state;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    instr_de0 = '0;
    if (w_grant_inj)
      instr_de0 = instr_inj;
    else if (!reset)
      instr_de0 = instr_fe1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_starve_cnt <= '0;
    end else begin
      if (w_nuke) begin
        r_state <= FLUSH;
      end else begin
        case (r_state)
          FLUSH:       r_state <= resume_fetch_rbx ? RUN : WAIT_RESUME;
          WAIT_RESUME: if (resume_fetch_rbx) r_state <= RUN;
          RUN:         if (w_grant_fe && is_ebreak_de0) r_state <= HALT;
          HALT:        r_state <= HALT;
          default:     r_state <= RUN;
        endcase
      end

      // A stalled queue freezes the starvation count rather than clearing it.
      if (w_nuke)
        r_starve_cnt <= '0;
      else if (!decode_ready_de0)
        r_starve_cnt <= r_starve_cnt;
      else if (w_grant_fe || !w_fetch_ok)
        r_starve_cnt <= '0;
      else if (w_grant_inj && !w_starved)
        r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  a_no_grant_in_recovery: assert property (@(posedge clk) disable iff (reset)
    (r_state == FLUSH || r_state == WAIT_RESUME) |-> !(fe_ready_fe1 || inj_ready));

  a_single_grant: assert property (@(posedge clk) disable iff (reset)
    !(fe_ready_fe1 && inj_ready));

endmodule

// File: tb/tb_decode_sched.sv
// Directed bench for decode_sched: reset, fetch streaming, starvation rotation,
// queue stall, nuke recovery, ebreak halt and reset out of HALT.
module tb_decode_sched;
  import instr_decode::*;

  localparam logic [3:0] G_NONE = 4'b0000;  // {fe_ready, inj_ready, valid, src_inj}
  localparam logic [3:0] G_FE   = 4'b1010;
  localparam logic [3:0] G_INJ  = 4'b0111;

  logic            clk = 1'b0;
  logic            reset;
  t_nuke_pkt       nuke_rb1;
  logic            resume_fetch_rbx;
  logic            decode_ready_de0;
  logic            valid_fe1;
  t_instr_pkt      instr_fe1;
  logic            fe_ready_fe1;
  logic            valid_inj;
  t_instr_pkt      instr_inj;
  logic            inj_ready;
  logic            is_ebreak_de0;
  logic            valid_de0;
  t_instr_pkt      instr_de0;
  logic            src_inj_de0;
  t_de_sched_state state_de0;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] flags;
  assign flags = {fe_ready_fe1, inj_ready, valid_de0, src_inj_de0};

  always #5 clk = ~clk;

  decode_sched #(.STARVE_MAX(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .nuke_rb1         (nuke_rb1),
    .resume_fetch_rbx (resume_fetch_rbx),
    .decode_ready_de0 (decode_ready_de0),
    .valid_fe1        (valid_fe1),
    .instr_fe1        (instr_fe1),
    .fe_ready_fe1     (fe_ready_fe1),
    .valid_inj        (valid_inj),
    .instr_inj        (instr_inj),
    .inj_ready        (inj_ready),
    .is_ebreak_de0    (is_ebreak_de0),
    .valid_de0        (valid_de0),
    .instr_de0        (instr_de0),
    .src_inj_de0      (src_inj_de0),
    .state_de0        (state_de0)
  );

  function automatic t_instr_pkt mk_instr(input logic [15:0] id);
    t_instr_pkt p;
    p.pc    = {14'd0, id, 2'b00};
    p.raw   = 32'h0000_0013 + {16'd0, id};
    p.simid = id;
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle's inputs, then lets combinational outputs settle.
  task automatic drive(input logic vf, input logic vi, input logic rdy,
                       input logic nk, input logic rs, input logic eb,
                       input logic [15:0] id);
    valid_fe1        = vf;
    valid_inj        = vi;
    decode_ready_de0 = rdy;
    nuke_rb1.valid   = nk;
    nuke_rb1.rob_id  = 6'd5;
    resume_fetch_rbx = rs;
    is_ebreak_de0    = eb;
    instr_fe1        = mk_instr(id);
    instr_inj        = mk_instr(16'h8000 | id);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      drive(1, 1, 1, 0, 0, 0, 16'd1 + 16'(c));
      n_checks++;
      if (flags !== G_NONE) begin
        n_errors++;
        $display("FAIL reset_flags[%0d]: got %b expected %b", c, flags, G_NONE);
      end
      n_checks++;
      if (instr_de0 !== '0) begin
        n_errors++;
        $display("FAIL reset_instr[%0d]: got %h expected 0", c, instr_de0);
      end
      n_checks++;
      if (state_de0 !== RUN) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got %0d expected RUN", c, state_de0);
      end
    end
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 1, 0, 0, 0, 16'd3);
    n_checks++;
    if (state_de0 !== RUN || dut.r_starve_cnt !== 3'd0 || flags !== G_NONE) begin
      n_errors++;
      $display("FAIL reset_release: got state=%0d cnt=%0d flags=%b expected RUN 0 0000",
               state_de0, dut.r_starve_cnt, flags);
    end
  endtask

  task automatic test_fetch_only();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      drive(1, 0, 1, 0, 0, 0, 16'h10 + 16'(c));
      n_checks++;
      if (flags !== G_FE) begin
        n_errors++;
        $display("FAIL fetch_flags[%0d]: got %b expected %b", c, flags, G_FE);
      end
      n_checks++;
      if (instr_de0 !== mk_instr(16'h10 + 16'(c))) begin
        n_errors++;
        $display("FAIL fetch_instr[%0d]: got %h expected %h", c, instr_de0,
                 mk_instr(16'h10 + 16'(c)));
      end
    end
  endtask

  task automatic test_starve();
    logic [3:0] exp;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      drive(1, 1, 1, 0, 0, 0, 16'h20 + 16'(c));
      exp = ((c % 5) == 4) ? G_FE : G_INJ;
      n_checks++;
      if (flags !== exp) begin
        n_errors++;
        $display("FAIL starve_flags[%0d]: got %b expected %b", c, flags, exp);
      end
      n_checks++;
      if (dut.r_starve_cnt !== 3'(c % 5)) begin
        n_errors++;
        $display("FAIL starve_cnt[%0d]: got %0d expected %0d", c, dut.r_starve_cnt, c % 5);
      end
      n_checks++;
      if (exp == G_INJ && instr_de0 !== mk_instr(16'h8000 | (16'h20 + 16'(c)))) begin
        n_errors++;
        $display("FAIL starve_instr[%0d]: got %h expected injected packet", c, instr_de0);
      end
    end
  endtask

  task automatic test_ready_low();
    logic [3:0] exp_f [8] = '{G_INJ, G_INJ, G_NONE, G_NONE, G_NONE, G_INJ, G_INJ, G_FE};
    logic [2:0] exp_c [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      drive(1, 1, (c < 2 || c > 4), 0, 0, 0, 16'h30 + 16'(c));
      n_checks++;
      if (flags !== exp_f[c] || dut.r_starve_cnt !== exp_c[c]) begin
        n_errors++;
        $display("FAIL ready_low[%0d]: got flags=%b cnt=%0d expected flags=%b cnt=%0d",
                 c, flags, dut.r_starve_cnt, exp_f[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_nuke();
    // cycle: nuke, FLUSH, WAIT, WAIT, WAIT+resume, RUN, nuke, FLUSH+resume, RUN
    logic            nk [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic            rs [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    logic [3:0]      ef [9] = '{G_NONE, G_NONE, G_NONE, G_NONE, G_NONE, G_FE,
                                G_NONE, G_NONE, G_FE};
    t_de_sched_state es [9] = '{RUN, FLUSH, WAIT_RESUME, WAIT_RESUME, WAIT_RESUME,
                                RUN, RUN, FLUSH, RUN};
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      drive(1, 0, 1, nk[c], rs[c], 0, 16'h40 + 16'(c));
      n_checks++;
      if (flags !== ef[c] || state_de0 !== es[c]) begin
        n_errors++;
        $display("FAIL nuke[%0d]: got flags=%b state=%0d expected flags=%b state=%0d",
                 c, flags, state_de0, ef[c], es[c]);
      end
    end
  endtask

  task automatic test_halt();
    logic            vf [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    logic            vi [10] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    logic            nk [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic            rs [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic            eb [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    logic [3:0]      ef [10] = '{G_FE, G_INJ, G_INJ, G_NONE, G_NONE, G_NONE, G_NONE,
                                 G_INJ, G_INJ, G_FE};
    t_de_sched_state es [10] = '{RUN, HALT, HALT, HALT, HALT, FLUSH, WAIT_RESUME,
                                 RUN, RUN, RUN};
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      drive(vf[c], vi[c], 1, nk[c], rs[c], eb[c], 16'h50 + 16'(c));
      n_checks++;
      if (flags !== ef[c] || state_de0 !== es[c]) begin
        n_errors++;
        $display("FAIL halt[%0d]: got flags=%b state=%0d expected flags=%b state=%0d",
                 c, flags, state_de0, ef[c], es[c]);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    next_cycle();
    drive(1, 0, 1, 0, 0, 1, 16'h60);
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 16'h61);
    n_checks++;
    if (state_de0 !== HALT || flags !== G_NONE) begin
      n_errors++;
      $display("FAIL rst_halt_entry: got state=%0d flags=%b expected HALT 0000",
               state_de0, flags);
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      reset = 1'b1;
      drive(1, 1, 1, 0, 0, 0, 16'h62 + 16'(c));
      n_checks++;
      if (flags !== G_NONE || state_de0 !== RUN || instr_de0 !== '0) begin
        n_errors++;
        $display("FAIL rst_halt_during[%0d]: got flags=%b state=%0d instr=%h expected 0000 RUN 0",
                 c, flags, state_de0, instr_de0);
      end
    end
    next_cycle();
    reset = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 16'h64);
    n_checks++;
    if (state_de0 !== RUN || dut.r_starve_cnt !== 3'd0 || flags !== G_FE) begin
      n_errors++;
      $display("FAIL rst_halt_after: got state=%0d cnt=%0d flags=%b expected RUN 0 %b",
               state_de0, dut.r_starve_cnt, flags, G_FE);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 16'd0);
    test_reset();
    test_fetch_only();
    test_starve();
    test_ready_low();
    test_nuke();
    test_halt();
    test_reset_in_halt();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_sched.md
# decode_sched

Front-end scheduler for the decode stage. It arbitrates the single decode slot between the fetch stream and an injection port (debug/exception-handler uops). It also sequences decode through nuke recovery and ebreak halt, so that pushes into the decode uop queue only happen when they are legal. It sits between FE1 and the DE0 decode logic, and drives the selected instruction and its valid into the decoder.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive injection grants, while fetch is eligible and waiting, before fetch is forced to win one cycle. Range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- nuke_rb1  in  t_nuke_pkt  pipeline nuke; only `.valid` is used.
- resume_fetch_rbx  in  1  end of the nuke recovery window.
- decode_ready_de0  in  1  uop queue can accept a push this cycle.
- valid_fe1  in  1  fetch instruction available.
- instr_fe1  in  t_instr_pkt  fetch instruction.
- fe_ready_fe1  out  1  fetch instruction consumed this cycle.
- valid_inj  in  1  injected instruction available.
- instr_inj  in  t_instr_pkt  injected instruction.
- inj_ready  out  1  injected instruction consumed this cycle.
- is_ebreak_de0  in  1  decoder reports the selected instruction is U_EBREAK (combinational from instr_de0).
- valid_de0  out  1  push into decode this cycle.
- instr_de0  out  t_instr_pkt  selected instruction.
- src_inj_de0  out  1  selected source is injection.
- state_de0  out  t_de_sched_state  current FSM state (debug/perf).

## Operation
- FSM states: RUN, FLUSH, WAIT_RESUME, HALT. Reset state is RUN.
- Transitions, in priority order:
  - nuke_rb1.valid: FLUSH from any state.
  - FLUSH: RUN if resume_fetch_rbx is high this cycle, else WAIT_RESUME.
  - WAIT_RESUME: RUN when resume_fetch_rbx is high.
  - RUN: HALT when a fetch grant occurs with is_ebreak_de0 high.
  - HALT: leaves only via nuke.
- Eligibility:
  - fetch_ok = (state==RUN) & valid_fe1 & decode_ready_de0 & ~nuke_rb1.valid.
  - inj_ok = (state==RUN | state==HALT) & valid_inj & decode_ready_de0 & ~nuke_rb1.valid.
- Arbitration:
  - Injection wins by default.
  - Fetch wins when starve_cnt == STARVE_MAX, or when inj_ok is low.
  - At most one grant per cycle.
- Outputs:
  - fe_ready_fe1 = grant_fe; inj_ready = grant_inj.
  - valid_de0 = grant_fe | grant_inj.
  - instr_de0 and src_inj_de0 follow the granted source. instr_de0 is fetch data when nothing is granted.
- Ebreak rules:
  - An injected ebreak does not enter HALT.
  - A fetch ebreak granted in the same cycle as a nuke is impossible, because grants are blocked under nuke.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on cycles where grant_inj is high and fetch_ok is high.
  - Clears on grant_fe, on cycles where fetch_ok is low, on nuke, and on reset.
  - Saturates at STARVE_MAX.
- Reset:
  - While reset is high, all outputs are 0 (state_de0 = RUN) and no grant is issued.
  - A reset mid-HALT or mid-WAIT_RESUME returns to RUN on the next cycle.
- Assertion (ASSERT): no grant while state is FLUSH or WAIT_RESUME; fe_ready_fe1 & inj_ready never both high.

## Timing
- Grants and all data outputs are combinational from the current-cycle inputs and registered state. Latency is 0 cycles from FE1 valid to DE0 push.
- State and starve_cnt update at the clk edge after the triggering event. The first fetch grant after resume_fetch_rbx is the cycle following it.
- A nuke blocks grants in the same cycle it is asserted, then for FLUSH plus the whole WAIT_RESUME period.
- decode_ready_de0 low: no grant; state holds except for nuke/resume transitions; starve_cnt holds.

## Structure
- t_de_sched_state (enum: RUN, FLUSH, WAIT_RESUME, HALT) goes in the instr_decode package. STARVE_MAX stays a module parameter.
- No sub-module: the FSM, the counter and a 2-way mux fit in one module. The uop queue stays in decode; decode consumes valid_de0/instr_de0 in place of valid_fe1/instr_fe1.
- SIMULATION debug prints per grant give source and SIMID.

## Test plan
- Fetch only, valid_fe1 held for 5 cycles, decode_ready_de0=1 → fe_ready_fe1=1 and valid_de0=1 on each of the 5 cycles; src_inj_de0=0.
- Both sources valid continuously, STARVE_MAX=4 → grant pattern inj,inj,inj,inj,fe, repeating; starve_cnt shows 0,1,2,3,4 then back to 0.
- Nuke at cycle 10, resume_fetch_rbx at cycle 14 → no grants in cycles 10–14; state FLUSH at 11 and WAIT_RESUME at 12–14; first fetch grant at cycle 15.
- Fetch ebreak granted at cycle 3 → state HALT from cycle 4; fetch never granted; injections still granted. Nuke at cycle 9 then resume at cycle 11 → RUN at 12.
- decode_ready_de0=0 for 3 cycles with both sources valid → no readies, no valid_de0, starve_cnt unchanged.
- Reset asserted while in HALT with valid inputs → all outputs 0 during reset; state RUN and starve_cnt 0 on the cycle after reset drops.
